// File: rtl/tdpr_pkg.sv
// Shared definitions for the true-dual-port-RAM FIFO controller.
//   - Default address/data widths and the matching RAM depth.
//   - Encoding of the 2-entry output buffer occupancy, which is also the
//     buffer's word count (EMPTY=0, ONE=1, TWO=2).
package tdpr_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int DATA_SIZE = 8;
  localparam int RAM_SIZE  = 1 << ADDR_SIZE;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/tdpr_fifo_obuf.sv
// Two-entry output buffer that sits behind the RAM's registered read port
// and presents a valid/ready stream to the downstream sink.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   capture, cap_data   word arriving from RAM port B this cycle
//   pop                 downstream is taking the head word this cycle
//   buf_count           words currently held (0..2)
//   head_data           head word (m_data)
//   m_valid             buffer is non-empty
module tdpr_fifo_obuf
  import tdpr_pkg::*;
#(
  parameter int DATA_SIZE = tdpr_pkg::DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 capture,
  input  logic [DATA_SIZE-1:0] cap_data,
  input  logic                 pop,
  output logic [1:0]           buf_count,
  output logic [DATA_SIZE-1:0] head_data,
  output logic                 m_valid
);

  buf_state_e           state_q, state_d;
  logic [DATA_SIZE-1:0] head_q, head_d;
  logic [DATA_SIZE-1:0] tail_q, tail_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Capture and pop together keep the occupancy; the head shifts up when
  // two words are held, otherwise the new word replaces the departing head.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (capture && pop) begin
      if (state_q == BUF_TWO) begin
        head_d = tail_q;
        tail_d = cap_data;
      end else begin
        head_d = cap_data;
      end
    end else if (capture) begin
      if (state_q == BUF_EMPTY) begin
        head_d  = cap_data;
        state_d = BUF_ONE;
      end else begin
        tail_d  = cap_data;
        state_d = BUF_TWO;
      end
    end else if (pop) begin
      if (state_q == BUF_TWO) begin
        head_d  = tail_q;
        state_d = BUF_ONE;
      end else begin
        state_d = BUF_EMPTY;
      end
    end
  end

  assign buf_count = state_q;
  assign head_data = head_q;
  assign m_valid   = (state_q != BUF_EMPTY);

  // The read-issue rule never lets a third word arrive at a full buffer.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(state_q == BUF_TWO && capture && !pop));

endmodule

// File: rtl/tdpr_fifo_ctrl.sv
// Streaming FIFO controller around an external true dual-port RAM.
// Port A writes words from an upstream valid/ready source; port B reads
// them back (1-cycle registered data) into a 2-entry output buffer that
// feeds a downstream valid/ready sink.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   s_valid/s_ready/s_data    upstream stream
//   m_valid/m_ready/m_data    downstream stream
//   level                     words held: RAM + in-flight read + buffer
//   ram_*_a                   RAM write port
//   ram_*_b, ram_dout_b       RAM read port (we_b tied low)
module tdpr_fifo_ctrl
  import tdpr_pkg::*;
#(
  parameter int ADDR_SIZE = tdpr_pkg::ADDR_SIZE,
  parameter int DATA_SIZE = tdpr_pkg::DATA_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_SIZE-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic [ADDR_SIZE+1:0] level,
  output logic                 ram_en_a,
  output logic                 ram_we_a,
  output logic [ADDR_SIZE-1:0] ram_addr_a,
  output logic [DATA_SIZE-1:0] ram_din_a,
  output logic                 ram_en_b,
  output logic                 ram_we_b,
  output logic [ADDR_SIZE-1:0] ram_addr_b,
  input  logic [DATA_SIZE-1:0] ram_dout_b
);

  // ram_count equal to this value means every RAM location holds a word.
  localparam logic [ADDR_SIZE:0] FULL_COUNT = {1'b1, {ADDR_SIZE{1'b0}}};

  logic [ADDR_SIZE-1:0] wptr_q, wptr_d;
  logic [ADDR_SIZE-1:0] rptr_q, rptr_d;
  logic [ADDR_SIZE:0]   ram_count_q, ram_count_d;
  logic                 inflight_q, inflight_d;

  logic       write;
  logic       issue;
  logic       pop;
  logic [1:0] buf_count;
  logic [2:0] occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      ram_count_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ram_count_q <= ram_count_d;
      inflight_q  <= inflight_d;
    end
  end

  // A read is only issued when the word has guaranteed room in the output
  // buffer, counting the read already in flight and this cycle's pop.
  always_comb begin
    s_ready = !rst && (ram_count_q < FULL_COUNT);
    write   = s_valid && s_ready;
    pop     = m_valid && m_ready;
    occ     = 3'(buf_count) + 3'(inflight_q);
    issue   = (ram_count_q != '0) && (occ < (3'd2 + 3'(pop)));

    wptr_d      = write ? wptr_q + 1'b1 : wptr_q;
    rptr_d      = issue ? rptr_q + 1'b1 : rptr_q;
    inflight_d  = issue;
    ram_count_d = ram_count_q;
    if (write && !issue) begin
      ram_count_d = ram_count_q + 1'b1;
    end else if (issue && !write) begin
      ram_count_d = ram_count_q - 1'b1;
    end
  end

  assign ram_en_a   = write;
  assign ram_we_a   = write;
  assign ram_addr_a = wptr_q;
  assign ram_din_a  = s_data;
  assign ram_en_b   = issue;
  assign ram_we_b   = 1'b0;
  assign ram_addr_b = rptr_q;

  tdpr_fifo_obuf #(
    .DATA_SIZE(DATA_SIZE)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .capture  (inflight_q),
    .cap_data (ram_dout_b),
    .pop      (pop),
    .buf_count(buf_count),
    .head_data(m_data),
    .m_valid  (m_valid)
  );

  assign level = (ADDR_SIZE+2)'(ram_count_q) + (ADDR_SIZE+2)'(inflight_q)
               + (ADDR_SIZE+2)'(buf_count);

  // Reads need ram_count>0 and wptr==rptr only when full (no write then),
  // so the two ports can never touch the same address together.
  a_no_collision: assert property (@(posedge clk) disable iff (rst)
    !(ram_en_a && ram_en_b && (ram_addr_a == ram_addr_b)));

endmodule

// File: tb/tb_tdpr_fifo_ctrl.sv
// Directed and randomised bench for tdpr_fifo_ctrl with a 16-entry RAM model.
module tb_tdpr_fifo_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [AW+1:0] level;
  logic          ram_en_a, ram_we_a, ram_en_b, ram_we_b;
  logic [AW-1:0] ram_addr_a, ram_addr_b;
  logic [DW-1:0] ram_din_a;
  wire  [DW-1:0] ram_dout_b;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] q[$];

  always #5 clk = ~clk;

  tdpr_fifo_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .level(level),
    .ram_en_a(ram_en_a), .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_en_b(ram_en_b), .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_dout_b(ram_dout_b)
  );

  // True dual-port RAM model with a registered port-B read.
  logic [DW-1:0] mem [1<<AW];
  logic [DW-1:0] rd_data = '0;
  logic          rd_valid = 1'b0;
  always @(posedge clk) begin
    rd_valid <= ram_en_b;
    if (ram_en_b) rd_data <= mem[ram_addr_b];
    if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_din_a;
  end
  assign ram_dout_b = rd_valid ? rd_data : 'z;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hEE; m_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_s_ready got=%b exp=0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (level !== 6'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    checks++; if (m_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_m_data got=%h exp=00", m_data); end
    checks++; if ({ram_en_a, ram_we_a, ram_en_b, ram_we_b} !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_ram_en got=%b exp=0000", {ram_en_a, ram_we_a, ram_en_b, ram_we_b});
    end
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b0;
    #1;
    checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_s_ready got=%b exp=1", s_ready); end
  endtask

  task automatic test_latency();
    logic [DW-1:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    @(negedge clk);
    m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h11;
    #1;
    checks++; if (ram_en_a !== 1'b1 || ram_addr_a !== 4'd0 || ram_din_a !== 8'h11) begin
      failures++; $display("[TB] FAIL lat_write_port got=%b/%0d/%h exp=1/0/11", ram_en_a, ram_addr_a, ram_din_a);
    end
    @(negedge clk); s_data = 8'h22; #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL lat_edge1_m_valid got=%b exp=0", m_valid); end
    @(negedge clk); s_data = 8'h33; #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("[TB] FAIL lat_edge2_m_valid got=%b exp=0", m_valid); end
    @(negedge clk); s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (m_valid !== 1'b1 || m_data !== exp_d[i]) begin
        failures++; $display("[TB] FAIL lat_out%0d got=%b/%h exp=1/%h", i, m_valid, m_data, exp_d[i]);
      end
      @(negedge clk);
    end
    #1;
    checks++; if (m_valid !== 1'b0 || level !== 6'd0) begin
      failures++; $display("[TB] FAIL lat_empty got=%b/%0d exp=0/0", m_valid, level);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_data = 8'(acc);
      #1;
      if (!s_ready) break;
      acc++;
    end
    s_valid = 1'b0;
    checks++; if (acc != 18) begin failures++; $display("[TB] FAIL bp_accepts got=%0d exp=18", acc); end
    repeat (3) @(negedge clk);
    #1;
    checks++; if (level !== 6'd18) begin failures++; $display("[TB] FAIL bp_level got=%0d exp=18", level); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_s_ready got=%b exp=0", s_ready); end
    @(negedge clk);
    m_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      #1;
      checks++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin
        failures++; $display("[TB] FAIL bp_drain%0d got=%b/%h exp=1/%h", i, m_valid, m_data, 8'(i));
      end
      @(negedge clk);
    end
    #1;
    checks++; if (m_valid !== 1'b0 || level !== 6'd0) begin
      failures++; $display("[TB] FAIL bp_empty got=%b/%0d exp=0/0", m_valid, level);
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] wexp = 4'd5;
    logic [AW-1:0] rexp = 4'd5;
    int wraps = 0;
    q.delete();
    m_ready = 1'b1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      s_valid = (i < 100);
      s_data  = 8'(8'h40 + i);
      #1;
      if (m_valid) begin
        checks++;
        if (q.size() == 0 || m_data !== q[0]) begin
          failures++; $display("[TB] FAIL stream_data got=%h exp=%h", m_data, (q.size() != 0) ? q[0] : 8'hxx);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      checks++; if (level > 6'd3) begin failures++; $display("[TB] FAIL stream_level got=%0d exp<=3", level); end
      checks++; if (ram_en_a && ram_en_b && ram_addr_a == ram_addr_b) begin
        failures++; $display("[TB] FAIL stream_collision got=addr%0d exp=distinct", ram_addr_a);
      end
      if (ram_en_b) begin
        checks++; if (ram_addr_b !== rexp) begin failures++; $display("[TB] FAIL stream_raddr got=%0d exp=%0d", ram_addr_b, rexp); end
        rexp++;
      end
      if (s_valid && s_ready) begin
        q.push_back(s_data);
        checks++; if (ram_en_a !== 1'b1 || ram_addr_a !== wexp) begin
          failures++; $display("[TB] FAIL stream_waddr got=%b/%0d exp=1/%0d", ram_en_a, ram_addr_a, wexp);
        end
        wexp++;
        if (wexp == 4'd0) wraps++;
      end
    end
    checks++; if (wraps <= 5) begin failures++; $display("[TB] FAIL stream_wraps got=%0d exp>5", wraps); end
    checks++; if (q.size() != 0 || level !== 6'd0) begin
      failures++; $display("[TB] FAIL stream_drained got=%0d/%0d exp=0/0", q.size(), level);
    end
  endtask

  task automatic test_random();
    q.delete();
    for (int i = 0; i < 10040; i++) begin
      @(negedge clk);
      s_data = 8'($urandom);
      if (i < 10000) begin
        s_valid = ($urandom_range(0, 3) != 0);
        m_ready = ((i / 500) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      end else begin
        s_valid = 1'b0;
        m_ready = 1'b1;
      end
      #1;
      checks++; if (level !== 6'(q.size())) begin
        failures++; $display("[TB] FAIL rand_level cyc=%0d got=%0d exp=%0d", i, level, q.size());
      end
      checks++; if (ram_en_a && ram_en_b && ram_addr_a == ram_addr_b) begin
        failures++; $display("[TB] FAIL rand_collision got=addr%0d exp=distinct", ram_addr_a);
      end
      if (m_valid && m_ready) begin
        checks++;
        if (q.size() == 0 || m_data !== q[0]) begin
          failures++; $display("[TB] FAIL rand_data cyc=%0d got=%h exp=%h", i, m_data, (q.size() != 0) ? q[0] : 8'hxx);
        end
        if (q.size() != 0) void'(q.pop_front());
      end
      if (s_valid && s_ready) q.push_back(s_data);
    end
    checks++; if (q.size() != 0 || m_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rand_drained got=%0d/%b exp=0/0", q.size(), m_valid);
    end
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); s_valid = 1'b1; s_data = 8'(8'h80 + i);
    end
    @(negedge clk); s_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (level !== 6'd8) begin failures++; $display("[TB] FAIL rm_level8 got=%0d exp=8", level); end
    m_ready = 1'b1;
    @(negedge clk); m_ready = 1'b0;
    #1;
    checks++; if (level !== 6'd7 || m_data !== 8'h81) begin
      failures++; $display("[TB] FAIL rm_level7 got=%0d/%h exp=7/81", level, m_data);
    end
    rst = 1'b1;
    #1;
    checks++; if (level !== 6'd0 || m_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL rm_cleared got=%0d/%b exp=0/0", level, m_valid);
    end
    checks++; if (ram_en_b !== 1'b0 || s_ready !== 1'b0) begin
      failures++; $display("[TB] FAIL rm_ports got=%b/%b exp=0/0", ram_en_b, s_ready);
    end
    @(negedge clk);
    rst = 1'b0; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1;
    @(negedge clk); s_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (m_valid && !seen) begin
        seen = 1;
        checks++; if (m_data !== 8'hA5) begin failures++; $display("[TB] FAIL rm_next_word got=%h exp=a5", m_data); end
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin failures++; $display("[TB] FAIL rm_timeout got=no_word exp=a5"); end
    #1;
    checks++; if (level !== 6'd0) begin failures++; $display("[TB] FAIL rm_final_level got=%0d exp=0", level); end
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    test_reset();
    test_latency();
    test_backpressure();
    test_stream();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
